// File: rtl/tl_tx_tlp_builder.sv
// TLP builder: gathers one DMA request (MRd or MWr with up to 8 payload DWs)
// and emits a 4-DW 64-bit-address header beat plus 128-bit payload beats.
module tl_tx_tlp_builder #(
    parameter logic [15:0] REQ_ID = 16'h0100
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_tvalid,
    output logic         s_tready,
    input  logic         s_tlast,
    input  logic [95:0]  s_tuser,
    input  logic [31:0]  s_tdata,
    output logic         m_tvalid,
    input  logic         m_tready,
    output logic         m_tlast,
    output logic [127:0] m_tdata,
    output logic [3:0]   m_tkeep,
    output logic         err,
    output logic         busy,
    output logic [7:0]   tag_cnt
);

    localparam logic [2:0] OP_MRD = 3'b001;
    localparam logic [2:0] OP_MWR = 3'b010;

    typedef enum logic [2:0] {IDLE, COLLECT, DROP, HEADER, PAYLOAD} state_t;

    state_t       state;
    logic [63:0]  addr;
    logic         is_wr;
    logic [3:0]   len;
    logic [2:0]   beat_cnt;
    logic [31:0]  pbuf [8];

    // First-beat request fields
    logic [63:0]  in_addr;
    logic [2:0]   in_op;
    logic [7:0]   in_len;
    logic         in_valid;

    // Next payload beat (beat 1 when already in PAYLOAD, else beat 0)
    logic         pay_hi;
    logic [127:0] pay_data;
    logic [3:0]   pay_keep;
    logic         pay_last;

    assign in_addr  = s_tuser[95:32];
    assign in_op    = s_tuser[31:29];
    assign in_len   = s_tuser[7:0];
    assign in_valid = ((in_op == OP_MRD) || (in_op == OP_MWR)) &&
                      (in_len != 8'd0) && (in_len <= 8'd8);

    assign s_tready = (state == IDLE) || (state == COLLECT) || (state == DROP);
    assign busy     = (state != IDLE);
    assign pay_hi   = (state == PAYLOAD);

    function automatic logic [127:0] build_hdr(input logic wr, input logic [3:0] l,
                                               input logic [63:0] a, input logic [7:0] tag);
        logic [31:0] dw0, dw1;
        dw0 = {(wr ? 3'b011 : 3'b001), 5'b00000, 14'b0, 6'b0, l};
        dw1 = {REQ_ID, (wr ? 8'h00 : tag), ((l == 4'd1) ? 4'h0 : 4'hF), 4'hF};
        return {a[31:2], 2'b00, a[63:32], dw1, dw0};
    endfunction

    // Select the slots of the next payload beat, zeroing DWs past the length
    always_comb begin
        pay_data = '0;
        pay_keep = '0;
        for (int i = 0; i < 4; i++) begin
            if ({1'b0, pay_hi, 2'(i)} < len) begin
                pay_keep[i]          = 1'b1;
                pay_data[32*i +: 32] = pbuf[{pay_hi, 2'(i)}];
            end
        end
        pay_last = pay_hi || (len <= 4'd4);
    end

    // Request collection, tlast checking and registered TLP output
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tag_cnt  <= 8'h00;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tdata  <= '0;
            m_tkeep  <= '0;
            err      <= 1'b0;
            addr     <= '0;
            is_wr    <= 1'b0;
            len      <= '0;
            beat_cnt <= '0;
            for (int i = 0; i < 8; i++) pbuf[i] <= '0;
        end else begin
            err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (s_tvalid) begin
                        if (!in_valid) begin
                            err   <= 1'b1;
                            state <= s_tlast ? IDLE : DROP;
                        end else begin
                            addr     <= in_addr;
                            is_wr    <= (in_op == OP_MWR);
                            len      <= in_len[3:0];
                            pbuf[0]  <= s_tdata;
                            beat_cnt <= 3'd1;
                            if (in_op == OP_MRD) begin
                                state    <= HEADER;
                                m_tvalid <= 1'b1;
                                m_tdata  <= build_hdr(1'b0, in_len[3:0], in_addr, tag_cnt);
                                m_tkeep  <= 4'hF;
                                m_tlast  <= 1'b1;
                            end else if (in_len == 8'd1) begin
                                if (s_tlast) begin
                                    state    <= HEADER;
                                    m_tvalid <= 1'b1;
                                    m_tdata  <= build_hdr(1'b1, 4'd1, in_addr, 8'h00);
                                    m_tkeep  <= 4'hF;
                                    m_tlast  <= 1'b0;
                                end else begin
                                    err   <= 1'b1;
                                    state <= DROP;
                                end
                            end else if (s_tlast) begin
                                err   <= 1'b1;
                                state <= IDLE;
                            end else begin
                                state <= COLLECT;
                            end
                        end
                    end
                end
                COLLECT: begin
                    if (s_tvalid) begin
                        pbuf[beat_cnt] <= s_tdata;
                        beat_cnt       <= beat_cnt + 3'd1;
                        if ({1'b0, beat_cnt} == len - 4'd1) begin
                            if (s_tlast) begin
                                state    <= HEADER;
                                m_tvalid <= 1'b1;
                                m_tdata  <= build_hdr(1'b1, len, addr, 8'h00);
                                m_tkeep  <= 4'hF;
                                m_tlast  <= 1'b0;
                            end else begin
                                err   <= 1'b1;
                                state <= DROP;
                            end
                        end else if (s_tlast) begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (s_tvalid && s_tlast) state <= IDLE;
                end
                HEADER: begin
                    if (m_tready) begin
                        if (!is_wr) begin
                            m_tvalid <= 1'b0;
                            m_tlast  <= 1'b0;
                            tag_cnt  <= tag_cnt + 8'd1;
                            state    <= IDLE;
                        end else begin
                            m_tdata <= pay_data;
                            m_tkeep <= pay_keep;
                            m_tlast <= pay_last;
                            state   <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (m_tready) begin
                        if (m_tlast) begin
                            m_tvalid <= 1'b0;
                            m_tlast  <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            m_tdata <= pay_data;
                            m_tkeep <= pay_keep;
                            m_tlast <= pay_last;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
